model_test_mul_pipe_hs: RTL and testbench
=========================================

// Module: model_test_mul_pipe_hs
// PURPOSE
//  Parametrised, pipelined multiplier with a valid/ready handshake. Each operand has its own signedness.
//  The output is either truncated (wrap) or saturated, and every overflow is flagged.
//  Used where the combinational mul_*_1_1 instances break timing, or where producers/consumers stall.
//  Throughput is 1 product/cycle; latency is NUM_STAGE cycles when there is no backpressure.
// PARAMETERS
//  ID          1   instance tag, no functional effect
//  NUM_STAGE   3   pipeline register stages, >=1; stage 0 captures operands, last stage drives dout
//  din0_WIDTH  12  operand 0 width
//  din1_WIDTH  7   operand 1 width
//  dout_WIDTH  18  result width, 2..din0_WIDTH+din1_WIDTH
//  DIN0_SIGNED 1   1: din0 two's complement; 0: unsigned (zero-extended)
//  DIN1_SIGNED 0   1: din1 two's complement; 0: unsigned (zero-extended)
//  SATURATE    0   0: keep low dout_WIDTH bits (wrap); 1: clamp to dout range
// PORTS
//  ap_clk    in   1                 clock, all logic on rising edge
//  ap_rst    in   1                 synchronous reset, active-high
//  ce        in   1                 global enable; 0 freezes every register and blocks both handshakes
//  din0      in   din0_WIDTH        operand 0
//  din1      in   din1_WIDTH        operand 1
//  din_vld   in   1                 operands valid
//  din_rdy   out  1                 block accepts operands this cycle
//  dout      out  dout_WIDTH        result
//  dout_vld  out  1                 dout/ovf valid
//  dout_rdy  in   1                 consumer accepts result
//  ovf       out  1                 per-result overflow flag, aligned with dout
//  ovf_stk   out  1                 sticky overflow: set on any accepted result with ovf=1
//  ovf_clr   in   1                 clears ovf_stk (setting event in same cycle wins)
// BEHAVIOUR
//  Reset: all stage valids, dout, dout_vld, ovf and ovf_stk = 0. Samples in flight are discarded.
//   Reset mid-stall has no residue.
//  Arithmetic: P = din0_WIDTH+din1_WIDTH.
//   Each operand is extended to P bits per its *_SIGNED; full-precision product prod[P-1:0].
//   Result is signed if DIN0_SIGNED|DIN1_SIGNED, else unsigned.
//  Overflow: prod is not representable in dout_WIDTH under the result signedness.
//  Output: SATURATE=0 -> dout = prod[dout_WIDTH-1:0].
//   SATURATE=1 -> on overflow, dout = max or min of the signed range, or all-ones if unsigned.
//   Otherwise dout = prod[dout_WIDTH-1:0].
//  Pipeline: the multiply may be retimed across stages. Each stage k holds vld[k].
//   Stage k loads from k-1 when ce && (!vld[k] || adv[k]).
//   adv[last] = dout_rdy; adv[k] = adv[k+1] || !vld[k+1] (bubble collapse).
//  din_rdy = ce && (!vld[0] || adv[0]). This is combinational from dout_rdy; there is no comb path din_vld->din_rdy.
//   Input transfer: din_vld && din_rdy.
//  dout_vld = vld[last]. Output transfer: dout_vld && dout_rdy && ce.
//   dout, ovf and dout_vld are held stable while dout_vld && !dout_rdy.
//  Simultaneous output transfer and new arrival into last stage -> new value replaces, dout_vld stays 1.
//  Latency: input transfer at cycle t -> dout_vld at t+NUM_STAGE when unstalled.
//  Full: all vld=1 and dout_rdy=0 -> din_rdy=0. Capacity is exactly NUM_STAGE samples; none dropped or duplicated.
//  ce=0: no state changes, din_rdy=0, no output transfer counted; dout_vld/dout unchanged.
//  ovf_stk: set on output transfer with ovf=1. Cleared by ovf_clr unless set in same cycle.
//  Order preserved: outputs appear in input-transfer order.
// TESTING
//  Defaults, SATURATE=0: din0=-5 (0xFFB), din1=100, dout_rdy=1 -> 3 cycles later dout=0x3FE0C (-500), ovf=0.
//  SATURATE=0: din0=-2048, din1=127 -> dout=0x00800, ovf=1, ovf_stk=1 after transfer.
//   Same with SATURATE=1 -> dout=0x20000 (-131072), ovf=1.
//  Stream 10 samples back-to-back, dout_rdy=1 -> 10 consecutive dout_vld, correct order, din_rdy never low.
//  dout_rdy=0 from first result: 3 accepted, then din_rdy=0.
//   Raise dout_rdy -> 3 results emerge in order and dout held stable while stalled.
//   Random ready/valid, 1000 samples -> matches reference model.
//  Assert ap_rst with 2 samples in flight -> next cycle dout_vld=0, ovf_stk=0.
//   A post-reset sample has latency 3 and no stale output.
//  ce=0 for 4 cycles mid-stream -> no transfers, outputs frozen. Resume -> identical sequence to ce=1 run.
//   Also cover DIN0_SIGNED=DIN1_SIGNED=0, SATURATE=1: 4095*127 -> dout=0x3FFFF, ovf=1.

Source files
------------

// File: rtl/model_test_mul_pipe_hs.sv
// rtl/model_test_mul_pipe_hs.sv - pipelined multiplier with valid/ready handshake, wrap or saturate, overflow flags
module model_test_mul_pipe_hs #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 12,
    parameter int din1_WIDTH  = 7,
    parameter int dout_WIDTH  = 18,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int SATURATE    = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din_vld,
    output logic                  din_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic                  ovf,
    output logic                  ovf_stk,
    input  logic                  ovf_clr
);

    localparam int P = din0_WIDTH + din1_WIDTH;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    logic [NUM_STAGE-1:0] vld;
    logic [NUM_STAGE-1:0] load;
    logic [P-1:0]         a_ext;
    logic [P-1:0]         b_ext;
    logic [P-1:0]         op_a;
    logic [P-1:0]         op_b;
    logic [P-1:0]         last_prod;
    logic [P-1:0]         back;

    assign a_ext = {{din1_WIDTH{(DIN0_SIGNED != 0) & din0[din0_WIDTH-1]}}, din0};
    assign b_ext = {{din0_WIDTH{(DIN1_SIGNED != 0) & din1[din1_WIDTH-1]}}, din1};

    // A stage may load when it is empty, or when any stage downstream of it is
    // empty or the consumer is taking the head (bubble collapse).
    always_comb begin
        logic hole;
        hole = 1'b0;
        load = '0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            load[k] = ce && (!vld[k] || dout_rdy || hole);
            hole    = hole || !vld[k];
        end
    end

    assign din_rdy  = load[0];
    assign dout_vld = vld[NUM_STAGE-1];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld <= '0;
        end else begin
            if (load[0]) vld[0] <= din_vld;
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (load[k]) vld[k] <= vld[k-1];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (load[0] && din_vld) begin
            op_a <= a_ext;
            op_b <= b_ext;
        end
    end

    // The multiply sits between stage 0 and stage 1; later stages only carry the product.
    generate
        if (NUM_STAGE > 1) begin : g_prod_pipe
            logic [P-1:0] pq [1:NUM_STAGE-1];

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    for (int k = 1; k < NUM_STAGE; k++) pq[k] <= '0;
                end else begin
                    if (load[1]) pq[1] <= op_a * op_b;
                    for (int k = 2; k < NUM_STAGE; k++) begin
                        if (load[k]) pq[k] <= pq[k-1];
                    end
                end
            end

            assign last_prod = pq[NUM_STAGE-1];
        end else begin : g_prod_comb
            assign last_prod = op_a * op_b;
        end
    endgenerate

    // Overflow: re-extending the kept low bits does not reproduce the full product.
    always_comb begin
        back = '0;
        for (int i = 0; i < P; i++) begin
            back[i] = (i < dout_WIDTH) ? last_prod[i] : (RES_SIGNED & last_prod[dout_WIDTH-1]);
        end
        ovf  = (back != last_prod);
        dout = last_prod[dout_WIDTH-1:0];
        if ((SATURATE != 0) && ovf) begin
            if (!RES_SIGNED)
                dout = '1;
            else if (last_prod[P-1])
                dout = {1'b1, {(dout_WIDTH-1){1'b0}}};
            else
                dout = {1'b0, {(dout_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ovf_stk <= 1'b0;
        end else if (ce) begin
            if (dout_vld && dout_rdy && ovf)
                ovf_stk <= 1'b1;
            else if (ovf_clr)
                ovf_stk <= 1'b0;
        end
    end

endmodule

// File: tb/tb_model_test_mul_pipe_hs.sv
// tb/tb_model_test_mul_pipe_hs.sv - directed and random checks of the pipelined handshake multiplier
module tb_model_test_mul_pipe_hs;

    logic        clk;
    logic        ap_rst;
    logic        ce;
    logic [11:0] din0;
    logic [6:0]  din1;
    logic        din_vld;
    logic        dout_rdy;
    logic        ovf_clr;

    logic        m_rdy, m_vld, m_ovf, m_stk;
    logic [17:0] m_dout;
    logic        s_rdy, s_vld, s_ovf, s_stk;
    logic [17:0] s_dout;
    logic        u_rdy, u_vld, u_ovf, u_stk;
    logic [17:0] u_dout;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [18:0] q [$];

    model_test_mul_pipe_hs u_main (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .din_rdy(m_rdy), .dout(m_dout), .dout_vld(m_vld),
        .dout_rdy(dout_rdy), .ovf(m_ovf), .ovf_stk(m_stk), .ovf_clr(ovf_clr)
    );

    model_test_mul_pipe_hs #(.SATURATE(1)) u_sat (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .din_rdy(s_rdy), .dout(s_dout), .dout_vld(s_vld),
        .dout_rdy(dout_rdy), .ovf(s_ovf), .ovf_stk(s_stk), .ovf_clr(ovf_clr)
    );

    model_test_mul_pipe_hs #(.DIN0_SIGNED(0), .DIN1_SIGNED(0), .SATURATE(1)) u_uns (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .din_rdy(u_rdy), .dout(u_dout), .dout_vld(u_vld),
        .dout_rdy(dout_rdy), .ovf(u_ovf), .ovf_stk(u_stk), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] ref_mul(input logic [11:0] a, input logic [6:0] b,
                                            input bit s0, input bit s1, input bit sat);
        longint av, bv, p, lo, hi, r;
        bit ov;
        av = s0 ? longint'($signed(a)) : longint'(a);
        bv = s1 ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        lo = (s0 || s1) ? -longint'(131072) : longint'(0);
        hi = (s0 || s1) ? longint'(131071) : longint'(262143);
        ov = (p < lo) || (p > hi);
        r  = (sat && ov) ? ((p < lo) ? lo : hi) : p;
        return {ov, r[17:0]};
    endfunction

    // Scoreboard, hold/freeze checks; transfers are judged on the values present before the edge.
    logic        hold;
    logic        pv, po;
    logic [17:0] pd;
    initial hold = 1'b0;
    always @(negedge clk) begin
        if (ap_rst) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_vld", m_vld, pv);
                chk("hold_dout", m_dout, pd);
                chk("hold_ovf", m_ovf, po);
            end
            if (!ce) chk("rdy_ce0", m_rdy, 0);
            if (m_vld && dout_rdy && ce) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    logic [18:0] ab, e;
                    ab = q.pop_front();
                    e = ref_mul(ab[18:7], ab[6:0], 1, 0, 0);
                    chk("m_dout", m_dout, e[17:0]);
                    chk("m_ovf", m_ovf, e[18]);
                    e = ref_mul(ab[18:7], ab[6:0], 1, 0, 1);
                    chk("s_dout", s_dout, e[17:0]);
                    chk("s_ovf", s_ovf, e[18]);
                    e = ref_mul(ab[18:7], ab[6:0], 0, 0, 1);
                    chk("u_dout", u_dout, e[17:0]);
                    chk("u_ovf", u_ovf, e[18]);
                end
            end
            if (din_vld && m_rdy) q.push_back({din0, din1});
            hold = !ce || (m_vld && !dout_rdy);
            pv = m_vld;
            pd = m_dout;
            po = m_ovf;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample, then stop at the negedge where its result is first visible.
    task automatic one(input logic [11:0] a, input logic [6:0] b, output int lat);
        din0 = a;
        din1 = b;
        din_vld = 1'b1;
        @(negedge clk);
        chk("one_rdy", m_rdy, 1);
        tick();
        din_vld = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_vld && lat < 10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int lat, acc, cyc, base;
        bit [19:0] vh;
        int rdy_low;

        ap_rst = 1'b1; ce = 1'b1; din0 = '0; din1 = '0;
        din_vld = 1'b0; dout_rdy = 1'b1; ovf_clr = 1'b0;
        repeat (3) tick();
        ap_rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", m_vld, 0);
        chk("rst_dout", m_dout, 0);
        chk("rst_ovf", m_ovf, 0);
        chk("rst_stk", m_stk, 0);
        chk("rst_rdy", m_rdy, 1);
        tick();

        one(12'hFFB, 7'd100, lat);
        chk("lat_a", lat, 3);
        chk("a_dout", m_dout, 18'h3FE0C);
        chk("a_ovf", m_ovf, 0);
        tick();

        one(12'h800, 7'd127, lat);
        chk("lat_b", lat, 3);
        chk("b_dout", m_dout, 18'h00800);
        chk("b_ovf", m_ovf, 1);
        chk("b_sdout", s_dout, 18'h20000);
        chk("b_sovf", s_ovf, 1);
        tick();
        @(negedge clk);
        chk("b_stk", m_stk, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_stk", m_stk, 0);

        one(12'h800, 7'd127, lat);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("stk_set_wins", m_stk, 1);

        one(12'hFFF, 7'd127, lat);
        chk("c_udout", u_dout, 18'h3FFFF);
        chk("c_uovf", u_ovf, 1);
        chk("c_dout", m_dout, 18'h3FF81);
        tick();
        repeat (3) tick();

        rdy_low = 0;
        base = n_out;
        for (int c = 0; c < 20; c++) begin
            din_vld = (c < 10);
            din0 = 12'(c * 409 + 7);
            din1 = 7'(c * 13 + 1);
            @(negedge clk);
            vh[c] = m_vld;
            if (c < 10 && !m_rdy) rdy_low++;
            tick();
        end
        chk("stream_rdy_low", rdy_low, 0);
        chk("stream_vld_run", 32'(vh[12:3]), 32'h3FF);
        chk("stream_vld_pre", 32'(vh[2:0]), 0);
        chk("stream_vld_post", 32'(vh[19:13]), 0);
        chk("stream_count", n_out - base, 10);

        dout_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            din_vld = 1'b1;
            din0 = 12'(acc * 37 + 2047);
            din1 = 7'(acc + 60);
            @(negedge clk);
            if (m_rdy) acc++;
            tick();
        end
        din_vld = 1'b0;
        chk("stall_acc", acc, 3);
        @(negedge clk);
        chk("stall_rdy", m_rdy, 0);
        base = n_out;
        tick();
        dout_rdy = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("stall_out", n_out - base, 3);
        tick();

        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            din_vld = ($urandom_range(0, 3) != 0);
            dout_rdy = ($urandom_range(0, 2) != 0);
            din0 = 12'($urandom);
            din1 = 7'($urandom);
            @(negedge clk);
            if (din_vld && m_rdy) acc++;
            tick();
            cyc++;
        end
        chk("rand_acc", acc, 1000);
        din_vld = 1'b0;
        dout_rdy = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("rand_drain", q.size(), 0);
        tick();

        one(12'h800, 7'd127, lat);
        tick();
        din_vld = 1'b1;
        din0 = 12'h123;
        din1 = 7'd9;
        tick();
        din0 = 12'h456;
        tick();
        din_vld = 1'b0;
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        @(negedge clk);
        chk("rst2_vld", m_vld, 0);
        chk("rst2_stk", m_stk, 0);
        tick();
        one(12'hFFB, 7'd100, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_dout", m_dout, 18'h3FE0C);
        tick();
        repeat (3) tick();

        acc = 0;
        for (int c = 0; c < 16; c++) begin
            din_vld = 1'b1;
            din0 = 12'(acc * 111 + 3);
            din1 = 7'(acc * 5 + 2);
            ce = !(c >= 6 && c < 10);
            @(negedge clk);
            if (m_rdy) acc++;
            tick();
        end
        ce = 1'b1;
        din_vld = 1'b0;
        chk("ce_acc", acc, 12);
        repeat (6) tick();
        @(negedge clk);
        chk("ce_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
